// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and bus payload type for the two-master device-bus arbiter.
package bus_arbiter_pkg;

   localparam logic        ARB_S_IDLE       = 1'b0;
   localparam logic        ARB_S_BURST      = 1'b1;
   localparam int unsigned ARB_BURST_MAX    = 8;
   localparam int unsigned ARB_STARVE_LIMIT = 4;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WE_W   = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned STAT_W = 32;

   typedef enum logic {
      S_IDLE  = ARB_S_IDLE,
      S_BURST = ARB_S_BURST
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic [WE_W-1:0]   we;
   } bus_beat_t;

endpackage

// File: rtl/arb_stats.sv
// Free-running wrapping counters of CPU stall cycles and DMA-granted beats.
// Only present when ARB_STATS_EN is defined.
`ifdef ARB_STATS_EN
module arb_stats
   import bus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_stall,
   input  logic              dma_beat,
   output logic [STAT_W-1:0] stat_cpu_stall,
   output logic [STAT_W-1:0] stat_dma_beats
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cpu_stall <= '0;
         stat_dma_beats <= '0;
      end else begin
         if (cpu_stall) stat_cpu_stall <= stat_cpu_stall + STAT_W'(1);
         if (dma_beat)  stat_dma_beats <= stat_dma_beats + STAT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/bus_arbiter.sv
// CPU / DMA arbiter sharing the single Bridge port; DMA gets locked bursts with starvation protection.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned BURST_MAX    = ARB_BURST_MAX,
   parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_valid,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wd,
   input  logic [WE_W-1:0]   cpu_we,
   input  logic              cpu_int_req,
   output logic [DATA_W-1:0] cpu_rd,
   output logic              cpu_stall,
   input  logic              dma_valid,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wd,
   input  logic [WE_W-1:0]   dma_we,
   input  logic              dma_last,
   output logic              dma_ready,
   output logic [DATA_W-1:0] dma_rd,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wd,
   output logic [WE_W-1:0]   bus_we,
   output logic              bus_req,
   input  logic [DATA_W-1:0] bus_rd,
   output logic [STAT_W-1:0] stat_cpu_stall,
   output logic [STAT_W-1:0] stat_dma_beats
);

   arb_state_e       st, st_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_nxt, beat_inc;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   logic             gnt_cpu, gnt_dma, force_dma;
   bus_beat_t        cpu_beat, dma_beat, bus_beat;

   // Grants are combinational so a granted beat completes in the same cycle; reset kills both.
   always_comb begin
      gnt_cpu   = 1'b0;
      gnt_dma   = 1'b0;
      force_dma = dma_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
      if (!reset) begin
         if (st == S_BURST) begin
            gnt_dma = dma_valid;
         end else if (force_dma) begin
            gnt_dma = 1'b1;
         end else if (cpu_valid) begin
            gnt_cpu = 1'b1;
         end else if (dma_valid) begin
            gnt_dma = 1'b1;
         end
      end
   end

   // Next-state: burst lock, beat counting and saturating starvation counter.
   always_comb begin
      st_nxt     = st;
      beat_nxt   = beat_cnt;
      starve_nxt = starve_cnt;
      beat_inc   = beat_cnt + CNT_W'(1);

      if (gnt_dma || !dma_valid) begin
         starve_nxt = '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         starve_nxt = starve_cnt + CNT_W'(1);
      end

      if (st == S_IDLE) begin
         if (gnt_dma) begin
            beat_nxt = CNT_W'(1);
            st_nxt   = (!dma_last && (BURST_MAX > 1)) ? S_BURST : S_IDLE;
         end
      end else if (gnt_dma) begin
         beat_nxt = beat_inc;
         if (dma_last || (beat_inc == CNT_W'(BURST_MAX))) st_nxt = S_IDLE;
      end else begin
         // DMA dropped its request mid-burst: release the lock.
         st_nxt   = S_IDLE;
         beat_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= S_IDLE;
         beat_cnt   <= '0;
         starve_cnt <= '0;
      end else begin
         st         <= st_nxt;
         beat_cnt   <= beat_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   assign cpu_beat = '{addr: cpu_addr, wd: cpu_wd, we: cpu_we};
   assign dma_beat = '{addr: dma_addr, wd: dma_wd, we: dma_we};

   // Bus mux; Bridge req is only raised for an interrupted CPU access.
   always_comb begin
      bus_beat = '0;
      bus_req  = 1'b0;
      if (gnt_dma) begin
         bus_beat = dma_beat;
      end else if (gnt_cpu) begin
         bus_beat = cpu_beat;
         bus_req  = cpu_int_req;
      end
   end

   assign bus_addr  = bus_beat.addr;
   assign bus_wd    = bus_beat.wd;
   assign bus_we    = bus_beat.we;
   assign cpu_rd    = bus_rd;
   assign dma_rd    = bus_rd;
   assign cpu_stall = cpu_valid && !gnt_cpu && !reset;
   assign dma_ready = gnt_dma;

`ifdef ARB_STATS_EN
   arb_stats u_stats (
      .clk            (clk),
      .reset          (reset),
      .cpu_stall      (cpu_stall),
      .dma_beat       (gnt_dma),
      .stat_cpu_stall (stat_cpu_stall),
      .stat_dma_beats (stat_dma_beats)
   );
`else
   assign stat_cpu_stall = '0;
   assign stat_dma_beats = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int unsigned BM = 8;
   localparam int unsigned SL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_valid, cpu_int_req, dma_valid, dma_last;
   logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd, bus_rd;
   logic [3:0]  cpu_we, dma_we;
   logic [31:0] cpu_rd, dma_rd, bus_addr, bus_wd, stat_cpu_stall, stat_dma_beats;
   logic [3:0]  bus_we;
   logic        cpu_stall, dma_ready, bus_req;

   always #5 clk = ~clk;

   bus_arbiter #(.BURST_MAX(BM), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
      .cpu_int_req(cpu_int_req), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
      .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wd(dma_wd), .dma_we(dma_we),
      .dma_last(dma_last), .dma_ready(dma_ready), .dma_rd(dma_rd),
      .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_we(bus_we), .bus_req(bus_req),
      .bus_rd(bus_rd), .stat_cpu_stall(stat_cpu_stall), .stat_dma_beats(stat_dma_beats)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: whether DMA holds a lock, beats taken under it, cycles DMA has waited.
   bit          m_locked;
   int          m_beats, m_wait;
   int unsigned m_stalls, m_dma_beats;
   bit          e_cpu, e_dma, e_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0; m_beats = 0; m_wait = 0; m_stalls = 0; m_dma_beats = 0;
   endtask

   task automatic check_outputs();
      logic [31:0] ea, ew;
      logic [3:0]  ewe;
      logic        er;
      e_cpu = 1'b0; e_dma = 1'b0;
      if (!reset) begin
         if (m_locked)                                e_dma = dma_valid;
         else if (dma_valid && m_wait >= int'(SL))    e_dma = 1'b1;
         else if (cpu_valid)                          e_cpu = 1'b1;
         else if (dma_valid)                          e_dma = 1'b1;
      end
      e_stall = cpu_valid && !e_cpu && !reset;
      ea = '0; ew = '0; ewe = '0; er = 1'b0;
      if (e_dma) begin
         ea = dma_addr; ew = dma_wd; ewe = dma_we;
      end else if (e_cpu) begin
         ea = cpu_addr; ew = cpu_wd; ewe = cpu_we; er = cpu_int_req;
      end
      check("bus_addr",   bus_addr, ea);
      check("bus_wd",     bus_wd, ew);
      check("bus_we",     32'(bus_we), 32'(ewe));
      check("bus_req",    32'(bus_req), 32'(er));
      check("cpu_stall",  32'(cpu_stall), 32'(e_stall));
      check("dma_ready",  32'(dma_ready), 32'(e_dma));
      check("cpu_rd",     cpu_rd, bus_rd);
      check("dma_rd",     dma_rd, bus_rd);
      check("st",         32'(dut.st), 32'(m_locked));
      check("beat_cnt",   32'(dut.beat_cnt), 32'(m_beats));
      check("starve_cnt", 32'(dut.starve_cnt), 32'(m_wait));
`ifdef ARB_STATS_EN
      check("stat_cpu_stall", stat_cpu_stall, m_stalls);
      check("stat_dma_beats", stat_dma_beats, m_dma_beats);
`else
      check("stat_cpu_stall", stat_cpu_stall, 32'd0);
      check("stat_dma_beats", stat_dma_beats, 32'd0);
`endif
   endtask

   task automatic model_update();
      if (reset) begin
         model_reset();
      end else begin
         m_stalls    += 32'(e_stall);
         m_dma_beats += 32'(e_dma);
         if (e_dma) begin
            m_wait = 0;
            if (!m_locked) begin
               m_beats  = 1;
               m_locked = !dma_last && (BM > 1);
            end else begin
               m_beats++;
               if (dma_last || m_beats == int'(BM)) m_locked = 1'b0;
            end
         end else begin
            if (m_locked) begin
               m_locked = 1'b0;
               m_beats  = 0;
            end
            m_wait = dma_valid ? ((m_wait + 1 > int'(SL)) ? int'(SL) : m_wait + 1) : 0;
         end
      end
   endtask

   // One clock: check mid-cycle, advance model at the edge, return just after it.
   task automatic step();
      bus_rd = $urandom;
      #3;
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Reset raised between edges: outputs must collapse before the next clock.
   task automatic mid_reset();
      bus_rd = $urandom;
      #3;
      check_outputs();
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_cpu(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we, input logic irq);
      cpu_valid = v; cpu_addr = a; cpu_wd = d; cpu_we = we; cpu_int_req = irq;
   endtask

   task automatic set_dma(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we, input logic last);
      dma_valid = v; dma_addr = a; dma_wd = d; dma_we = we; dma_last = last;
   endtask

   initial begin
      reset = 1'b1;
      bus_rd = '0;
      set_cpu(1'b0, '0, '0, '0, 1'b0);
      set_dma(1'b0, '0, '0, '0, 1'b0);
      model_reset();
      @(posedge clk);
      #1;

      // Requests during reset are ignored
      set_cpu(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
      set_dma(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
      step();
      reset = 1'b0;

      // CPU alone, then with interrupt, then interrupt without a request
      set_dma(1'b0, '0, '0, '0, 1'b0);
      set_cpu(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0);
      step();
      cpu_int_req = 1'b1;
      step();
      cpu_valid = 1'b0;
      step();

      // Collision then starvation: four CPU wins, forced DMA beat, CPU again
      set_cpu(1'b1, 32'h20, 32'h1111_2222, 4'h0, 1'b0);
      set_dma(1'b1, 32'h100, 32'hA5A5_A5A5, 4'h3, 1'b1);
      repeat (6) step();
      set_cpu(1'b0, '0, '0, '0, 1'b0);
      set_dma(1'b0, '0, '0, '0, 1'b0);
      step();

      // Three-beat burst with CPU arriving on beat two
      set_dma(1'b1, 32'h200, 32'h0BAD_F00D, 4'hF, 1'b0);
      step();
      cpu_valid = 1'b1; cpu_addr = 32'h30; dma_addr = 32'h204;
      step();
      dma_addr = 32'h208; dma_last = 1'b1;
      step();
      dma_valid = 1'b0; dma_last = 1'b0;
      step();
      cpu_valid = 1'b0;
      step();

      // Fourteen beats without dma_last: lock ends at BURST_MAX, CPU waiting from beat 8
      set_dma(1'b1, 32'h300, 32'h0, 4'h1, 1'b0);
      for (int i = 1; i <= 14; i++) begin
         cpu_valid = (i == 8 || i == 9);
         dma_addr  = 32'h300 + 32'(i * 4);
         dma_wd    = 32'(i);
         step();
      end
      set_dma(1'b0, '0, '0, '0, 1'b0);
      cpu_valid = 1'b0;
      step();

      // Reset asserted in the middle of a write burst
      set_dma(1'b1, 32'h400, 32'hCAFE_0000, 4'hF, 1'b0);
      step();
      step();
      mid_reset();
      step();
      reset = 1'b0;
      step();
      step();
      set_dma(1'b0, '0, '0, '0, 1'b0);
      step();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         set_cpu(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
         set_dma(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 4'($urandom),
                 1'($urandom_range(0, 3) == 0));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
